// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic {OWN_CORE, OWN_EXT} dmem_owner_t;

    localparam int DMEM_DATA_W = 32;

    // Width of a counter that must hold 0..max_wait (never narrower than 1 bit)
    function automatic int starve_cnt_w(input int max_wait);
        if (max_wait < 1) return 1;
        return $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/dmem_arb_starve_cnt.sv
// Saturating starvation counter: counts cycles the external port has been
// blocked by core traffic, flags when the forced-grant threshold is reached.
module dmem_arb_starve_cnt
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic at_max
);

    localparam int CW = starve_cnt_w(MAX_WAIT);
    localparam logic [CW-1:0] MAX_V = CW'(MAX_WAIT);

    logic [CW-1:0] cnt;

    assign at_max = (cnt == MAX_V);

    // Clear on grant/idle, otherwise count up and stick at the threshold
    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (inc && !at_max)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the core MEM stage and an external
// requester. Core has default priority; the starvation counter forces the
// external port in after MAX_WAIT blocked cycles (MAX_WAIT=0: ext strict
// priority). Optional perf counters under DMEM_ARBITER_PERF_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W   = DMEM_DATA_W,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [DATA_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [DATA_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] ext_rdata,
`ifdef DMEM_ARBITER_PERF_EN
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_ext_cnt,
`endif
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    dmem_owner_t owner;
    logic        core_act;
    logic        ext_act;
    logic        at_max;

    // Requests are ignored entirely while in reset
    assign core_act = core_req & ~rst;
    assign ext_act  = ext_req & ~rst;

    assign ext_gnt    = ext_act & (~core_act | at_max);
    assign core_stall = core_act & ext_gnt;
    assign owner      = ext_gnt ? OWN_EXT : OWN_CORE;
    assign core_rdata = mem_rd;

    dmem_arb_starve_cnt #(.MAX_WAIT(MAX_WAIT)) u_starve (
        .clk    (clk),
        .rst    (rst),
        .clr    (ext_gnt | ~ext_act),
        .inc    (core_act),
        .at_max (at_max)
    );

    // Memory port mux; idle cycles leave the core address on the bus with WE low
    always_comb begin
        mem_addr = core_addr;
        mem_wd   = core_wdata;
        mem_we   = core_we & core_act;
        if (owner == OWN_EXT) begin
            mem_addr = ext_addr;
            mem_wd   = ext_wdata;
            mem_we   = ext_we;
        end
    end

    // External read return: data captured at grant, presented next cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            ext_rvalid <= 1'b0;
            ext_rdata  <= '0;
        end else begin
            ext_rvalid <= ext_gnt & ~ext_we;
            if (ext_gnt && !ext_we)
                ext_rdata <= mem_rd;
        end
    end

`ifdef DMEM_ARBITER_PERF_EN
    // Saturating event counters for stall and external-grant cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_ext_cnt   <= '0;
        end else begin
            if (core_stall && perf_stall_cnt != 32'hFFFF_FFFF)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (ext_gnt && perf_ext_cnt != 32'hFFFF_FFFF)
                perf_ext_cnt <= perf_ext_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (MAX_WAIT=4 and MAX_WAIT=0), each with
// its own word memory, directed sequences plus a starvation vector table, then
// random traffic against a request-level reference model.
module tb_dmem_arbiter;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         core_req[2], core_we[2], ext_req[2], ext_we[2];
    logic [W-1:0] core_addr[2], core_wdata[2], ext_addr[2], ext_wdata[2];
    logic [W-1:0] core_rdata[2], ext_rdata[2], mem_addr[2], mem_wd[2], mem_rd[2];
    logic         core_stall[2], ext_gnt[2], ext_rvalid[2], mem_we[2];
`ifdef DMEM_ARBITER_PERF_EN
    logic [31:0]  perf_stall[2], perf_ext[2];
`endif

    dmem_arbiter #(.DATA_W(W), .MAX_WAIT(4)) dut4 (
        .clk(clk), .rst(rst),
        .core_req(core_req[0]), .core_we(core_we[0]), .core_addr(core_addr[0]),
        .core_wdata(core_wdata[0]), .core_rdata(core_rdata[0]), .core_stall(core_stall[0]),
        .ext_req(ext_req[0]), .ext_we(ext_we[0]), .ext_addr(ext_addr[0]),
        .ext_wdata(ext_wdata[0]), .ext_gnt(ext_gnt[0]), .ext_rvalid(ext_rvalid[0]),
        .ext_rdata(ext_rdata[0]),
`ifdef DMEM_ARBITER_PERF_EN
        .perf_stall_cnt(perf_stall[0]), .perf_ext_cnt(perf_ext[0]),
`endif
        .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wd(mem_wd[0]), .mem_rd(mem_rd[0])
    );

    dmem_arbiter #(.DATA_W(W), .MAX_WAIT(0)) dut0 (
        .clk(clk), .rst(rst),
        .core_req(core_req[1]), .core_we(core_we[1]), .core_addr(core_addr[1]),
        .core_wdata(core_wdata[1]), .core_rdata(core_rdata[1]), .core_stall(core_stall[1]),
        .ext_req(ext_req[1]), .ext_we(ext_we[1]), .ext_addr(ext_addr[1]),
        .ext_wdata(ext_wdata[1]), .ext_gnt(ext_gnt[1]), .ext_rvalid(ext_rvalid[1]),
        .ext_rdata(ext_rdata[1]),
`ifdef DMEM_ARBITER_PERF_EN
        .perf_stall_cnt(perf_stall[1]), .perf_ext_cnt(perf_ext[1]),
`endif
        .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wd(mem_wd[1]), .mem_rd(mem_rd[1])
    );

    // Environment memories: combinational read, write on the clock edge
    logic [W-1:0] env_mem[2][256];
    assign mem_rd[0] = env_mem[0][mem_addr[0][9:2]];
    assign mem_rd[1] = env_mem[1][mem_addr[1][9:2]];
    always @(posedge clk)
        for (int d = 0; d < 2; d++)
            if (mem_we[d]) env_mem[d][mem_addr[d][9:2]] <= mem_wd[d];

    // Reference model: "how long has the current ext request been blocked"
    int           maxw[2] = '{4, 0};
    int           blocked[2];
    int           age[2];
    logic         m_rvalid[2], m_last_gnt[2];
    logic [W-1:0] m_rdata[2];
    logic [W-1:0] ref_mem[2][256];

    function automatic logic m_gnt(input int d);
        return !rst && ext_req[d] && (!core_req[d] || blocked[d] >= maxw[d]);
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            m_last_gnt[d] <= m_gnt(d);
            if (rst) begin
                blocked[d]  <= 0;
                age[d]      <= 0;
                m_rvalid[d] <= 1'b0;
                m_rdata[d]  <= '0;
            end else begin
                if (m_gnt(d) || !ext_req[d]) blocked[d] <= 0;
                else if (core_req[d]) blocked[d] <= (blocked[d] + 1 > maxw[d]) ? maxw[d] : blocked[d] + 1;
                age[d] <= (m_gnt(d) || !ext_req[d]) ? 0 : age[d] + 1;
                m_rvalid[d] <= m_gnt(d) && !ext_we[d];
                if (m_gnt(d) && !ext_we[d]) m_rdata[d] <= ref_mem[d][ext_addr[d][9:2]];
                if (m_gnt(d) && ext_we[d]) ref_mem[d][ext_addr[d][9:2]] <= ext_wdata[d];
                else if (!m_gnt(d) && core_req[d] && core_we[d])
                    ref_mem[d][core_addr[d][9:2]] <= core_wdata[d];
            end
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Random-phase checker against the reference model
    logic chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                chk("rnd_gnt", ext_gnt[d], m_gnt(d));
                chk("rnd_stall", core_stall[d], m_gnt(d) && core_req[d]);
                chk("rnd_mem_we", mem_we[d], m_gnt(d) ? ext_we[d] : core_req[d] && core_we[d]);
                chk("rnd_mem_addr", mem_addr[d], m_gnt(d) ? ext_addr[d] : core_addr[d]);
                if (mem_we[d])
                    chk("rnd_mem_wd", mem_wd[d], m_gnt(d) ? ext_wdata[d] : core_wdata[d]);
                if (core_req[d] && !m_gnt(d))
                    chk("rnd_core_rdata", core_rdata[d], ref_mem[d][core_addr[d][9:2]]);
                chk("rnd_rvalid", ext_rvalid[d], m_rvalid[d]);
                if (m_rvalid[d]) chk("rnd_rdata", ext_rdata[d], m_rdata[d]);
                if (m_gnt(d)) chk("ext_wait_bound", age[d] <= maxw[d], 1);
            end
        end
    end

    typedef struct {
        logic         creq, cwe;
        logic [W-1:0] caddr;
        logic         ereq, ewe;
        logic [W-1:0] eaddr, ewd;
        logic         gnt, stall, mwe;
        logic [W-1:0] maddr;
    } vec_t;
    vec_t tbl[10];

    task automatic idle();
        for (int d = 0; d < 2; d++) begin
            core_req[d] = 0; core_we[d] = 0; core_addr[d] = 0; core_wdata[d] = 0;
            ext_req[d] = 0; ext_we[d] = 0; ext_addr[d] = 0; ext_wdata[d] = 0;
        end
    endtask

    task automatic next_cyc();
        @(posedge clk); #1;
    endtask

    initial begin
        // Starvation pattern on MAX_WAIT=4: forced grant every 5th cycle
        tbl[0] = '{1, 0, 32'h40, 1, 1, 32'h80, 32'hA5A50001, 0, 0, 0, 32'h40};
        tbl[1] = '{1, 0, 32'h40, 1, 1, 32'h80, 32'hA5A50001, 0, 0, 0, 32'h40};
        tbl[2] = '{1, 0, 32'h40, 1, 1, 32'h80, 32'hA5A50001, 0, 0, 0, 32'h40};
        tbl[3] = '{1, 0, 32'h40, 1, 1, 32'h80, 32'hA5A50001, 0, 0, 0, 32'h40};
        tbl[4] = '{1, 0, 32'h40, 1, 1, 32'h80, 32'hA5A50001, 1, 1, 1, 32'h80};
        tbl[5] = '{1, 1, 32'h44, 1, 1, 32'h84, 32'hA5A50002, 0, 0, 1, 32'h44};
        tbl[6] = '{1, 0, 32'h40, 1, 1, 32'h84, 32'hA5A50002, 0, 0, 0, 32'h40};
        tbl[7] = '{1, 0, 32'h40, 1, 1, 32'h84, 32'hA5A50002, 0, 0, 0, 32'h40};
        tbl[8] = '{1, 0, 32'h40, 1, 1, 32'h84, 32'hA5A50002, 0, 0, 0, 32'h40};
        tbl[9] = '{1, 0, 32'h40, 1, 1, 32'h84, 32'hA5A50002, 1, 1, 1, 32'h84};

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 256; i++) begin
                env_mem[d][i] = '0;
                ref_mem[d][i] = '0;
            end
        idle();
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            core_req[d] = 1; ext_req[d] = 1; core_we[d] = 1;
        end

        // Reset: requests ignored, outputs at reset values
        for (int c = 0; c < 2; c++) begin
            next_cyc();
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                chk("rst_gnt", ext_gnt[d], 0);
                chk("rst_stall", core_stall[d], 0);
                chk("rst_rvalid", ext_rvalid[d], 0);
                chk("rst_rdata", ext_rdata[d], 0);
                chk("rst_mem_we", mem_we[d], 0);
            end
        end

        // Core store then load, no ext traffic
        next_cyc();
        rst = 1'b0; idle();
        core_req[0] = 1; core_we[0] = 1; core_addr[0] = 32'h40; core_wdata[0] = 32'hDEADBEEF;
        @(negedge clk);
        chk("st_mem_we", mem_we[0], 1);
        chk("st_mem_addr", mem_addr[0], 32'h40);
        chk("st_mem_wd", mem_wd[0], 32'hDEADBEEF);
        chk("st_stall", core_stall[0], 0);
        next_cyc();
        core_we[0] = 0;
        @(negedge clk);
        chk("ld_rdata", core_rdata[0], 32'hDEADBEEF);
        chk("ld_mem_we", mem_we[0], 0);
        chk("ld_stall", core_stall[0], 0);

        // Ext read on an idle bus
        next_cyc();
        idle();
        ext_req[0] = 1; ext_addr[0] = 32'h40;
        @(negedge clk);
        chk("extrd_gnt", ext_gnt[0], 1);
        chk("extrd_mem_addr", mem_addr[0], 32'h40);
        next_cyc();
        idle();
        @(negedge clk);
        chk("extrd_rvalid", ext_rvalid[0], 1);
        chk("extrd_rdata", ext_rdata[0], 32'hDEADBEEF);
        chk("idle_gnt", ext_gnt[0], 0);
        next_cyc();
        @(negedge clk);
        chk("extrd_rvalid_drop", ext_rvalid[0], 0);
        chk("extrd_rdata_hold", ext_rdata[0], 32'hDEADBEEF);

        // Starvation table
        for (int i = 0; i < 10; i++) begin
            next_cyc();
            core_req[0] = tbl[i].creq; core_we[0] = tbl[i].cwe; core_addr[0] = tbl[i].caddr;
            core_wdata[0] = 32'h1111_0000 + i;
            ext_req[0] = tbl[i].ereq; ext_we[0] = tbl[i].ewe;
            ext_addr[0] = tbl[i].eaddr; ext_wdata[0] = tbl[i].ewd;
            @(negedge clk);
            chk($sformatf("tbl%0d_gnt", i), ext_gnt[0], tbl[i].gnt);
            chk($sformatf("tbl%0d_stall", i), core_stall[0], tbl[i].stall);
            chk($sformatf("tbl%0d_mem_we", i), mem_we[0], tbl[i].mwe);
            chk($sformatf("tbl%0d_mem_addr", i), mem_addr[0], tbl[i].maddr);
        end

        // MAX_WAIT=0: ext wins every cycle it requests
        next_cyc();
        idle();
        for (int c = 0; c < 3; c++) begin
            core_req[1] = 1; core_we[1] = 1; core_addr[1] = 32'h10; core_wdata[1] = 32'h12345678;
            ext_req[1] = 1; ext_we[1] = 0; ext_addr[1] = 32'h10;
            @(negedge clk);
            chk("mw0_gnt", ext_gnt[1], 1);
            chk("mw0_stall", core_stall[1], 1);
            chk("mw0_mem_we", mem_we[1], 0);
            if (c > 0) begin
                chk("mw0_rvalid", ext_rvalid[1], 1);
                chk("mw0_rdata", ext_rdata[1], 0);
            end
            next_cyc();
        end

        // Reset in the cycle after a granted read drops the pending response
        idle();
        ext_req[0] = 1; ext_addr[0] = 32'h80;
        @(negedge clk);
        chk("rstrd_gnt", ext_gnt[0], 1);
        next_cyc();
        rst = 1'b1;
        core_req[0] = 1; ext_req[0] = 1; ext_addr[0] = 32'h84;
        @(negedge clk);
        chk("rstrd_rvalid_pre", ext_rvalid[0], 1);
        chk("rstrd_rdata_pre", ext_rdata[0], 32'hA5A50001);
        chk("rstrd_gnt_in_rst", ext_gnt[0], 0);
        chk("rstrd_stall_in_rst", core_stall[0], 0);
        next_cyc();
        idle();
        @(negedge clk);
        chk("rstrd_rvalid_post", ext_rvalid[0], 0);
        chk("rstrd_rdata_post", ext_rdata[0], 0);
`ifdef DMEM_ARBITER_PERF_EN
        chk("perf_stall_rst", perf_stall[0], 0);
        chk("perf_ext_rst", perf_ext[0], 0);
`endif
        next_cyc();
        rst = 1'b0;

        // Random traffic against the reference model
        chk_en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            for (int d = 0; d < 2; d++) begin
                core_req[d]   = $urandom_range(0, 9) < 6;
                core_we[d]    = $urandom_range(0, 1) == 1;
                core_addr[d]  = W'($urandom_range(0, 15)) << 2;
                core_wdata[d] = $urandom;
                if (!ext_req[d] || m_last_gnt[d]) begin
                    ext_req[d]   = $urandom_range(0, 3) != 0;
                    ext_we[d]    = $urandom_range(0, 2) == 0;
                    ext_addr[d]  = W'($urandom_range(0, 15)) << 2;
                    ext_wdata[d] = $urandom;
                end
            end
            next_cyc();
        end
        @(negedge clk);
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
